res_edge_bank: RTL and testbench

//  Parametrised N-channel edge/event latch bank, successor to the single-channel RES edge register.
//  Per channel: selectable edge mode, sticky event flag, saturating event counter, plus bank-level

---
 rtl/res_edge_pkg.sv | 26 ++
 rtl/res_edge_cell.sv | 73 +++++++
 rtl/res_edge_bank.sv | 44 ++++
 tb/tb_res_edge_bank.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/res_edge_pkg.sv
// Shared definitions for the RES edge latch bank: per-channel edge modes and edge decode.
package res_edge_pkg;

    typedef enum logic [1:0] {
        MODE_RISE   = 2'b00,
        MODE_FALL   = 2'b01,
        MODE_BOTH   = 2'b10,
        MODE_LEGACY = 2'b11
    } mode_e;

    // Event decode from the previous and current input sample.
    function automatic logic edge_evt(input mode_e m, input logic prev, input logic s);
        logic rise;
        logic fall;
        rise = ~prev & s;
        fall = prev & ~s;
        case (m)
            MODE_RISE:   edge_evt = rise;
            MODE_FALL:   edge_evt = fall;
            MODE_BOTH:   edge_evt = rise | fall;
            MODE_LEGACY: edge_evt = rise;
            default:     edge_evt = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/res_edge_cell.sv
// One RES channel: optional 2-FF input synchroniser (RES_EDGE_BANK_SYNC_EN), edge detect,
// sticky flag and saturating event counter.
module res_edge_cell
    import res_edge_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          res_in,
    input  logic [1:0]    mode,
    input  logic          clr,
    output logic          res_out,
    output logic [CW-1:0] evt_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    mode_e         m;
    logic          s;
    logic          prev;
    logic          evt;
    logic [CW-1:0] cnt_base;

    assign m = mode_e'(mode);

`ifdef RES_EDGE_BANK_SYNC_EN
    logic sync1;
    logic sync2;

    // Both stages load the raw input in reset so s is coherent once reset releases.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync1 <= res_in;
            sync2 <= res_in;
        end else begin
            sync1 <= res_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = res_in;
`endif

    always_comb begin
        evt      = edge_evt(m, prev, s);
        cnt_base = clr ? '0 : evt_cnt;
    end

    // Clear-then-increment gives set priority over a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            prev    <= s;
            evt_cnt <= '0;
            res_out <= (m == MODE_LEGACY) ? s : 1'b0;
        end else begin
            prev <= s;
            if (evt && (cnt_base != CNT_MAX)) begin
                evt_cnt <= cnt_base + CW'(1);
            end else begin
                evt_cnt <= cnt_base;
            end
            if (m == MODE_LEGACY) begin
                res_out <= s & (res_out | evt);
            end else begin
                res_out <= evt | (res_out & ~clr);
            end
        end
    end

endmodule

// File: rtl/res_edge_bank.sv
// N-channel RES edge/event latch bank with ANY and lowest-active-channel summary.
// Optional input synchronisers enabled by defining RES_EDGE_BANK_SYNC_EN.
module res_edge_bank #(
    parameter  int unsigned N  = 4,
    parameter  int unsigned CW = 8,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    RESin,
    input  logic [2*N-1:0]  MODE,
    input  logic [N-1:0]    CLR,
    output logic [N-1:0]    RESout,
    output logic [N*CW-1:0] EVT_CNT,
    output logic            ANY,
    output logic [IW-1:0]   FIRST_IDX
);

    for (genvar i = 0; i < int'(N); i++) begin : g_ch
        res_edge_cell #(
            .CW(CW)
        ) u_cell (
            .CLK     (CLK),
            .RST     (RST),
            .res_in  (RESin[i]),
            .mode    (MODE[2*i+1:2*i]),
            .clr     (CLR[i]),
            .res_out (RESout[i]),
            .evt_cnt (EVT_CNT[CW*i +: CW])
        );
    end

    // Scan high to low so the lowest set channel is the final assignment.
    always_comb begin
        ANY       = |RESout;
        FIRST_IDX = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (RESout[i]) begin
                FIRST_IDX = IW'(i);
            end
        end
    end

endmodule

// File: tb/tb_res_edge_bank.sv
// Scoreboard bench for res_edge_bank (N=4, CW=8); honours RES_EDGE_BANK_SYNC_EN when defined.
module tb_res_edge_bank;

    localparam int N       = 4;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    RESin;
    logic [2*N-1:0]  MODE;
    logic [N-1:0]    CLR;
    logic [N-1:0]    RESout;
    logic [N*CW-1:0] EVT_CNT;
    logic            ANY;
    logic [1:0]      FIRST_IDX;

    res_edge_bank #(.N(N), .CW(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RESin     (RESin),
        .MODE      (MODE),
        .CLR       (CLR),
        .RESout    (RESout),
        .EVT_CNT   (EVT_CNT),
        .ANY       (ANY),
        .FIRST_IDX (FIRST_IDX)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N-1:0]    res;
        logic [N*CW-1:0] cnt;
        logic            any;
        logic [1:0]      idx;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    logic mp[N];
    logic mf[N];
    logic ms1[N];
    logic ms2[N];
    int   mc[N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance model with current inputs, push expectation, clock once, pop and compare.
    task automatic cycle();
        exp_t       e;
        exp_t       got;
        logic       s, rise, fall, ev;
        logic [1:0] md;
        bit         found;
        e = '0;
        for (int ch = 0; ch < N; ch++) begin
`ifdef RES_EDGE_BANK_SYNC_EN
            s = ms2[ch];
`else
            s = RESin[ch];
`endif
            md = MODE[2*ch +: 2];
            if (!RST) begin
                mf[ch] = (md == 2'b11) && s;
                mc[ch] = 0;
            end else begin
                rise = !mp[ch] && s;
                fall = mp[ch] && !s;
                case (md)
                    2'b00:   ev = rise;
                    2'b01:   ev = fall;
                    2'b10:   ev = rise || fall;
                    default: ev = rise;
                endcase
                if (CLR[ch]) mc[ch] = 0;
                if (ev && mc[ch] < CNT_MAX) mc[ch] = mc[ch] + 1;
                if (md == 2'b11) begin
                    if (!s) mf[ch] = 1'b0;
                    else if (ev) mf[ch] = 1'b1;
                end else begin
                    if (ev) mf[ch] = 1'b1;
                    else if (CLR[ch]) mf[ch] = 1'b0;
                end
            end
            mp[ch]  = s;
            ms2[ch] = RST ? ms1[ch] : RESin[ch];
            ms1[ch] = RESin[ch];
            e.res[ch]          = mf[ch];
            e.cnt[CW*ch +: CW] = CW'(mc[ch]);
        end
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mf[i] && !found) begin
                found = 1'b1;
                e.idx = 2'(i);
            end
        end
        e.any = found;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        chk("resout", 32'(RESout), 32'(got.res));
        chk("evt_cnt", 32'(EVT_CNT), 32'(got.cnt));
        chk("any", 32'(ANY), 32'(got.any));
        chk("first_idx", 32'(FIRST_IDX), 32'(got.idx));
    endtask

    initial begin
        RST  = 1'b0;
        CLR  = '0;
        MODE = 8'b00_10_11_00;
`ifdef RES_EDGE_BANK_SYNC_EN
        RESin = 4'b0011;
`else
        RESin = 4'b0010;
`endif
        repeat (2) @(posedge CLK);
        #1;
        for (int ch = 0; ch < N; ch++) begin
            ms1[ch] = RESin[ch];
            ms2[ch] = RESin[ch];
            mp[ch]  = RESin[ch];
            mf[ch]  = 1'b0;
            mc[ch]  = 0;
        end
        repeat (3) cycle();
        chk("rst_legacy_flag", 32'(RESout[1]), 32'd1);
        chk("rst_rise_flag", 32'(RESout[0]), 32'd0);
        chk("rst_cnt", 32'(EVT_CNT), 32'd0);
        RST = 1'b1;

`ifdef RES_EDGE_BANK_SYNC_EN
        repeat (4) cycle();
        chk("sync_no_evt", 32'(RESout[0]), 32'd0);
        chk("sync_no_cnt", 32'(EVT_CNT[7:0]), 32'd0);
        RESin[0] = 1'b0;
        repeat (3) cycle();
        RESin[0] = 1'b1;
        repeat (2) cycle();
        chk("sync_k2", 32'(RESout[0]), 32'd0);
        cycle();
        chk("sync_k3", 32'(RESout[0]), 32'd1);
        RESin[0] = 1'b0;
        repeat (3) cycle();
        CLR[0] = 1'b1;
        cycle();
        CLR[0] = 1'b0;
`endif

        RESin[0] = 1'b0;
        cycle();
        RESin[0] = 1'b1;
        cycle();
`ifndef RES_EDGE_BANK_SYNC_EN
        chk("t1_set", 32'(RESout[0]), 32'd1);
        chk("t1_cnt", 32'(EVT_CNT[7:0]), 32'd1);
`endif
        RESin[0] = 1'b0;
        repeat (2) cycle();
        chk("t1_hold", 32'(RESout[0]), 32'd1);
        CLR[0] = 1'b1;
        cycle();
        CLR[0] = 1'b0;
        chk("t1_clr_flag", 32'(RESout[0]), 32'd0);
        chk("t1_clr_cnt", 32'(EVT_CNT[7:0]), 32'd0);

        RESin[1] = 1'b0;
        cycle();
`ifndef RES_EDGE_BANK_SYNC_EN
        chk("t2_drop", 32'(RESout[1]), 32'd0);
`endif
        RESin[1] = 1'b1;
        cycle();
`ifndef RES_EDGE_BANK_SYNC_EN
        chk("t2_rise", 32'(RESout[1]), 32'd1);
        CLR[1] = 1'b1;
        cycle();
        CLR[1] = 1'b0;
        chk("t2_clr_ignored", 32'(RESout[1]), 32'd1);
        chk("t2_clr_cnt", 32'(EVT_CNT[15:8]), 32'd0);
`endif

        repeat (300) begin
            RESin[2] = ~RESin[2];
            cycle();
        end
        repeat (3) cycle();
        chk("t3_sat_cnt", 32'(EVT_CNT[23:16]), 32'd255);
        chk("t3_sat_flag", 32'(RESout[2]), 32'd1);

        RESin[3] = 1'b1; cycle();
        RESin[3] = 1'b0; cycle();
        RESin[3] = 1'b1; cycle();
        RESin[3] = 1'b0; cycle();
        RESin[3] = 1'b1;
        CLR[3]   = 1'b1;
        cycle();
        CLR[3] = 1'b0;
`ifndef RES_EDGE_BANK_SYNC_EN
        chk("t4_flag", 32'(RESout[3]), 32'd1);
        chk("t4_cnt", 32'(EVT_CNT[31:24]), 32'd1);
`endif
        repeat (2) cycle();

        CLR[2]   = 1'b1;
        RESin[1] = 1'b0;
        cycle();
        CLR[2] = 1'b0;
        repeat (2) cycle();
        chk("t5_idx3", 32'(FIRST_IDX), 32'd3);
        RESin[1] = 1'b1;
        repeat (3) cycle();
        chk("t5_any", 32'(ANY), 32'd1);
        chk("t5_idx1", 32'(FIRST_IDX), 32'd1);
        RESin[1] = 1'b0;
        repeat (3) cycle();
        chk("t5_idx3b", 32'(FIRST_IDX), 32'd3);
        CLR[3] = 1'b1;
        cycle();
        CLR[3] = 1'b0;
        chk("t5_none_any", 32'(ANY), 32'd0);
        chk("t5_none_idx", 32'(FIRST_IDX), 32'd0);

        MODE[1:0] = 2'b01;
        RESin[0]  = 1'b1;
        repeat (3) cycle();
        chk("mode_fall_no_rise", 32'(RESout[0]), 32'd0);
        RESin[0] = 1'b0;
        repeat (3) cycle();
        chk("mode_fall_set", 32'(RESout[0]), 32'd1);

        repeat (400) begin
            RESin = N'($urandom);
            CLR   = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 30) == 0) MODE = 8'($urandom);
            RST = ($urandom_range(0, 60) != 0);
            cycle();
        end
        RST = 1'b1;
        CLR = '0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
